// File: rtl/sopc_pio_ext_if.sv
// Avalon-MM slave bus bundle for the PIO peripheral: 3-bit word address,
// 32-bit data, zero wait states.
interface sopc_pio_ext_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/sopc_pio_ext.sv
// Parametrised PIO: output register with set/clear, synchronised inputs with
// per-bit rising/falling edge capture, and a maskable level interrupt.
module sopc_pio_ext_bit (
  input  logic prev,
  input  logic sync_in,
  input  logic sel,
  input  logic armed,
  input  logic cap,
  input  logic clr,
  output logic cap_nxt
);
  logic edge_hit;
  assign edge_hit = armed & (sel ? (prev & ~sync_in) : (~prev & sync_in));
  // A new edge beats a same-cycle clear so no event is ever lost.
  assign cap_nxt  = (cap & ~clr) | edge_hit;
endmodule

module sopc_pio_ext #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  sopc_pio_ext_if.slave    bus,
  output logic [WIDTH-1:0] out_port,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  typedef enum logic [2:0] {
    A_DATA = 3'd0, A_INPUT = 3'd1, A_SET = 3'd2, A_CLEAR = 3'd3,
    A_MASK = 3'd4, A_EDGE  = 3'd5, A_SEL = 3'd6, A_RSVD  = 3'd7
  } reg_addr_e;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d, out_q, out_d, mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d, sel_q, sel_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;

  logic [WIDTH-1:0] sync_in, wdata, clr, cap_nxt;
  logic [31:0]      rdata;
  logic             wr, armed;
  reg_addr_e        addr;
  logic             unused_wdata;

  assign unused_wdata = ^bus.writedata;
  assign addr    = reg_addr_e'(bus.address);
  assign wr      = bus.chipselect & ~bus.write_n;
  assign wdata   = bus.writedata[WIDTH-1:0];
  assign sync_in = sync_q[SYNC_STAGES-1];
  assign armed   = (arm_cnt_q == ARM_DONE);
  assign clr     = (wr && addr == A_EDGE) ? wdata : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sopc_pio_ext_bit u_bit (
      .prev    (prev_q[i]),
      .sync_in (sync_in[i]),
      .sel     (sel_q[i]),
      .armed   (armed),
      .cap     (cap_q[i]),
      .clr     (clr[i]),
      .cap_nxt (cap_nxt[i])
    );
  end

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], in_port};
    prev_d    = sync_in;
    // Edge detection stays off until the synchroniser and prev hold real
    // samples, so lines already high at reset never look like edges.
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
    cap_d     = cap_nxt;
    out_d     = out_q;
    mask_d    = mask_q;
    sel_d     = sel_q;
    if (wr) begin
      case (addr)
        A_DATA:  out_d  = wdata;
        A_SET:   out_d  = out_q | wdata;
        A_CLEAR: out_d  = out_q & ~wdata;
        A_MASK:  mask_d = wdata;
        A_SEL:   sel_d  = wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      A_DATA:  rdata[WIDTH-1:0] = out_q;
      A_INPUT: rdata[WIDTH-1:0] = sync_in;
      A_MASK:  rdata[WIDTH-1:0] = mask_q;
      A_EDGE:  rdata[WIDTH-1:0] = cap_q;
      A_SEL:   rdata[WIDTH-1:0] = sel_q;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      prev_q    <= '0;
      arm_cnt_q <= '0;
      out_q     <= RESET_VALUE;
      mask_q    <= '0;
      cap_q     <= '0;
      sel_q     <= '0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      arm_cnt_q <= arm_cnt_d;
      out_q     <= out_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      sel_q     <= sel_d;
    end
  end

  assign bus.readdata = rdata;
  assign out_port     = out_q;
  assign irq          = |(cap_q & mask_q);
endmodule

// File: tb/tb_sopc_pio_ext.sv
// Randomised and directed bench for sopc_pio_ext against an input-history
// reference model; outputs are compared on every falling clock edge.
module tb_sopc_pio_ext;
  localparam int         W  = 8;
  localparam int         S  = 2;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_port = 8'h00;
  logic [7:0] out_port;
  logic       irq;

  sopc_pio_ext_if bus_if ();

  sopc_pio_ext #(.WIDTH(W), .RESET_VALUE(RV), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .out_port (out_port),
    .in_port  (in_port),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit checking = 1'b0;

  // Model state: register values plus every in_port sample since reset release.
  logic [7:0] m_out, m_mask, m_cap, m_sel;
  int         n;
  logic [7:0] hist[$];

  // in_port sampled at edge j appears on the synchronised bus after edge j+S-1.
  function automatic logic [7:0] sync_after(int k);
    int idx;
    idx = k - S + 1;
    if (idx < 1) return 8'h00;
    return hist[idx];
  endfunction

  function automatic logic [31:0] model_rd(logic [2:0] a);
    case (a)
      3'd0:    return {24'b0, m_out};
      3'd1:    return {24'b0, sync_after(n)};
      3'd4:    return {24'b0, m_mask};
      3'd5:    return {24'b0, m_cap};
      3'd6:    return {24'b0, m_sel};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_out = RV; m_mask = 8'h00; m_cap = 8'h00; m_sel = 8'h00;
    n = 0;
    hist.delete();
    hist.push_back(8'h00);
  endtask

  task automatic model_edge();
    logic [7:0] pv, sy, ed, wd, cl;
    bit wr;
    if (!reset_n) return;
    n++;
    hist.push_back(in_port);
    sy = sync_after(n - 1);
    pv = sync_after(n - 2);
    ed = (n >= S + 2) ? ((m_sel & pv & ~sy) | (~m_sel & ~pv & sy)) : 8'h00;
    wr = bus_if.chipselect && !bus_if.write_n;
    wd = bus_if.writedata[7:0];
    cl = (wr && bus_if.address == 3'd5) ? wd : 8'h00;
    m_cap = (m_cap & ~cl) | ed;
    if (wr) begin
      case (bus_if.address)
        3'd0: m_out = wd;
        3'd2: m_out = m_out | wd;
        3'd3: m_out = m_out & ~wd;
        3'd4: m_mask = wd;
        3'd6: m_sel = wd;
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("out_port", {24'b0, out_port}, {24'b0, m_out});
      check("irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
      check("readdata", bus_if.readdata, model_rd(bus_if.address));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    bus_if.address = a; bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
    bus_if.writedata = d;
    tick();
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1; bus_if.writedata = 32'h0;
  endtask

  task automatic rd_lit(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus_if.address = a;
    #1;
    check(name, bus_if.readdata, exp);
  endtask

  initial begin
    bus_if.address = 3'd0; bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
    bus_if.writedata = 32'h0;
    model_reset();
    checking = 1'b1;
    repeat (3) tick();
    check("rst_out", {24'b0, out_port}, 32'hA5);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rd_lit("rst_mask", 3'd4, 32'h0);
    rd_lit("rst_cap", 3'd5, 32'h0);
    rd_lit("rst_sel", 3'd6, 32'h0);
    reset_n = 1'b1;
    repeat (5) tick();

    bus_wr(3'd0, 32'h0F); check("data_wr", {24'b0, out_port}, 32'h0F);
    bus_wr(3'd2, 32'h30); check("set_wr", {24'b0, out_port}, 32'h3F);
    bus_wr(3'd3, 32'h03); check("clr_wr", {24'b0, out_port}, 32'h3C);
    rd_lit("rd_set", 3'd2, 32'h0);
    rd_lit("rd_clr", 3'd3, 32'h0);

    bus_wr(3'd4, 32'h04);
    in_port = 8'h04;
    tick(); rd_lit("input_e1", 3'd1, 32'h00);
    tick(); rd_lit("input_e2", 3'd1, 32'h04);
    rd_lit("cap_e2", 3'd5, 32'h00);
    tick(); rd_lit("cap_e3", 3'd5, 32'h04);
    check("irq_e3", {31'b0, irq}, 32'h1);
    bus_wr(3'd5, 32'h04); check("irq_clr", {31'b0, irq}, 32'h0);

    bus_wr(3'd6, 32'h01);
    in_port = 8'h05;
    repeat (3) tick(); rd_lit("fall_rise", 3'd5, 32'h00);
    in_port = 8'h04;
    repeat (3) tick(); rd_lit("fall_fall", 3'd5, 32'h01);
    bus_wr(3'd5, 32'h01);

    in_port = 8'h00; repeat (3) tick();
    in_port = 8'h04; repeat (3) tick(); rd_lit("recap", 3'd5, 32'h04);
    in_port = 8'h00; repeat (3) tick();
    in_port = 8'h04; tick(); tick();
    bus_wr(3'd5, 32'h04); rd_lit("set_wins", 3'd5, 32'h04);
    bus_wr(3'd5, 32'h04); rd_lit("clr_after", 3'd5, 32'h00);

    reset_n = 1'b0; model_reset();
    in_port = 8'hFF;
    #1; check("midrst_out", {24'b0, out_port}, 32'hA5);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    rd_lit("arm_cap", 3'd5, 32'h00);
    bus_wr(3'd4, 32'hFF); check("arm_irq", {31'b0, irq}, 32'h0);

    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        reset_n = 1'b0; model_reset();
        tick(); tick();
        reset_n = 1'b1;
      end
      if ($urandom_range(3) == 0) in_port = in_port ^ (8'($urandom) & 8'($urandom));
      bus_if.chipselect = 1'($urandom_range(1));
      bus_if.write_n    = 1'($urandom_range(1));
      bus_if.address    = 3'($urandom);
      bus_if.writedata  = $urandom;
      tick();
    end

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/sopc_pio_ext.md
# sopc_pio_ext

Parametrised Avalon-MM parallel I/O peripheral for the SOPC system: the generalised successor of the single-bit output PIOs used to drive actuator control lines such as jack direction and enable. Provides a WIDTH-bit output register with atomic set/clear, a synchronised WIDTH-bit input port with per-bit edge capture (rising or falling), and a maskable level interrupt. Sits on the Nios II data master as an Avalon slave with zero wait states; out_port drives the actuator logic and in_port receives end-of-stroke and fault lines.

## Interface
- WIDTH, 8, number of output and input bits (1..32)
- RESET_VALUE, 0, value loaded into the output register at reset (WIDTH bits)
- SYNC_STAGES, 2, flip-flop stages on in_port before use (2..4)
- clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  reset, asynchronous, active-low; clock clk
- address  in  3  word register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; write when chipselect=1 and write_n=0
- writedata  in  32  write data; only bits [WIDTH-1:0] are used
- readdata  out  32  read data, combinational from address; bits [31:WIDTH] always 0
- out_port  out  WIDTH  output register contents
- in_port  in  WIDTH  asynchronous external inputs
- irq  out  1  level interrupt, active-high

## Operation
- Register map (word address):
  - 0 DATA: RW; write loads the output register; read returns the output register
  - 1 INPUT: RO; read returns the synchronised in_port value
  - 2 SET: WO; output register |= writedata; reads 0
  - 3 CLEAR: WO; output register &= ~writedata; reads 0
  - 4 IRQ_MASK: RW; per-bit interrupt enable
  - 5 EDGE_CAPTURE: RW1C; read returns captured edges; writing 1 to a bit clears it; writing 0 leaves it unchanged
  - 6 EDGE_SEL: RW; per bit, 0 = capture rising edge, 1 = capture falling edge
  - 7 reserved; reads 0; writes ignored
- Writes to RO or reserved addresses have no effect. Reads have no side effects.
- Synchroniser: in_port passes through SYNC_STAGES registers giving sync_in. A prev register holds the sync_in value from the previous cycle.
- Edge detection: edge[i] = EDGE_SEL[i] ? (prev[i] & ~sync_in[i]) : (~prev[i] & sync_in[i]).
- Capture: EDGE_CAPTURE[i] is set when edge[i]=1. A clear write and an edge on the same bit in the same cycle leave the bit set (set wins).
- Arming: a counter holds edge detection disabled for SYNC_STAGES+1 cycles after reset deassertion. This prevents in_port lines that are already high at reset from producing spurious captures.
- EDGE_SEL changes take effect on the next cycle. Changing EDGE_SEL does not clear existing captures.
- irq = |(EDGE_CAPTURE & IRQ_MASK), generated combinationally from registers.

## Timing
- Reset values: out_port = RESET_VALUE; IRQ_MASK, EDGE_CAPTURE, EDGE_SEL, synchroniser, prev and arming counter = 0; irq = 0; readdata = 0 when address maps to a zero register.
- Reset asserted mid-operation immediately restores all reset values, including captures, and restarts the arming counter.
- Write latency:
  - A DATA, SET or CLEAR write sampled at edge N is visible on out_port after edge N.
  - A mask write sampled at edge N affects irq after edge N.
- Read latency is 0 cycles: readdata is valid in the same cycle as address, with no wait states.
- Input latency (SYNC_STAGES=2): an in_port change stable before edge E1 reaches INPUT after E2. The capture bit and irq assert after E3, i.e. SYNC_STAGES+1 edges.
- Pulses on in_port shorter than one clock period may be missed. This is not an error.

## Test plan
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, irq=0; all readbacks at addresses 4, 5 and 6 read 0.
- Sequence: DATA write 8'h0F, then SET 8'h30, then CLEAR 8'h03 -> out_port is 8'h0F, then 8'h3F, then 8'h3C, each visible one edge after its write; reads of addresses 2 and 3 return 0.
- Rising edge on in_port[2] with IRQ_MASK=8'h04 -> INPUT bit 2 = 1 after 2 edges; EDGE_CAPTURE=8'h04 and irq=1 after 3 edges. Writing 8'h04 to address 5 -> irq=0 on the next cycle.
- EDGE_SEL=8'h01; pulse in_port[0] high then low -> capture bit 0 set only after the falling edge; the rising edge produces no capture.
- Hold in_port=8'hFF through reset release -> no capture bits set and irq stays 0.
- Clear write to bit 2 in the same cycle as a new rising edge on bit 2 -> bit remains 1.
